ulx3s_reset_sequencer: RTL and testbench
========================================

Name: ulx3s_reset_sequencer

Overview:
- Sits directly downstream of the ULX3S PLL. Consumes the PLL `locked` flag and produces staged, glitch-filtered reset releases for the SDRAM, memory-controller and CPU logic.
- Runs on one PLL output clock (the 50 MHz CPU clock).
- Guarantees the release order: SDRAM first, then memory, then CPU.
- Re-asserts all resets on loss of lock, and supports a CPU-only soft reset.

Parameters:
- LOCK_STABLE_CYCLES, 1024, cycles the synchronised `locked` must stay high before SDRAM reset releases (≥1).
- SDRAM_WAIT_CYCLES, 10000, cycles between SDRAM release and memory release (200 µs at 50 MHz) (≥1).
- STAGE_GAP_CYCLES, 16, cycles between memory release and CPU release (≥1).
- SOFT_HOLD_CYCLES, 16, cycles the CPU reset is held on a soft reset (≥1).
- CNT_W, 16, stage counter width; must hold max(parameter)−1.

Ports:
- clock  in  1  system clock, from a PLL output.
- reset_n  in  1  asynchronous, active-low reset.
- pll_locked  in  1  PLL lock flag; asynchronous to `clock`.
- soft_reset  in  1  synchronous request; sampled each cycle.
- rst_sdram  out  1  active-high SDRAM-domain reset.
- rst_memory  out  1  active-high memory-controller reset.
- rst_cpu  out  1  active-high CPU reset.
- ready  out  1  high only in RUN state.
- lock_loss_count  out  8  saturating count of lock losses after SDRAM release.

Behaviour:
- Reset and clocking: one clock, `clock`. Reset is asynchronous and active-low on `reset_n`.
- While `reset_n` is low:
  - state = WAIT_LOCK;
  - synchroniser flops = 0;
  - counter = 0;
  - rst_sdram = rst_memory = rst_cpu = 1;
  - ready = 0;
  - lock_loss_count = 0.
- Synchroniser: `pll_locked` passes through a 2-flop synchroniser to give `lk_s`. `lk_s` lags by 2 edges.
- Outputs: all outputs are registered and change on the edge that enters a state.
- WAIT_LOCK: all resets 1. If `lk_s` = 1, go to STABLE and clear the counter.
- STABLE: all resets 1.
  - If `lk_s` = 0, return to WAIT_LOCK; the loss is not counted.
  - Otherwise increment the counter. When counter == LOCK_STABLE_CYCLES−1, go to SDRAM and set rst_sdram = 0.
- SDRAM: rst_sdram = 0. Count to SDRAM_WAIT_CYCLES−1, then go to MEM with rst_memory = 0 and the counter cleared.
- MEM: count to STAGE_GAP_CYCLES−1, then go to RUN with rst_cpu = 0 and ready = 1.
- RUN: if soft_reset = 1, go to SOFT with rst_cpu = 1, ready = 0 and the counter cleared.
- SOFT: count to SOFT_HOLD_CYCLES−1, then return to RUN with rst_cpu = 0 and ready = 1.
  - soft_reset = 1 while in SOFT restarts the counter at 0.
- soft_reset outside RUN/SOFT: ignored.
- Lock loss: `lk_s` = 0 in SDRAM, MEM, RUN or SOFT (checked before any other transition):
  - next edge goes to WAIT_LOCK with all resets 1 and ready 0;
  - lock_loss_count increments, saturating at 255.
- Simultaneous events: lock loss has priority over soft_reset and over counter completion.
- Latency: let edge k be the first edge at which flop 1 samples `pll_locked` = 1, with `pll_locked` held high.
  - rst_sdram falls at edge k+2+LOCK_STABLE_CYCLES.
  - rst_memory falls SDRAM_WAIT_CYCLES edges later.
  - rst_cpu and ready change STAGE_GAP_CYCLES edges after that.
- Soft-reset width: rst_cpu is high for exactly SOFT_HOLD_CYCLES cycles, unless retriggered.
- Output invariants, required in every cycle:
  - rst_sdram ≤ rst_memory ≤ rst_cpu (a later stage is never released before an earlier one);
  - ready = ~rst_cpu & ~rst_memory & ~rst_sdram.
- Counter: one shared CNT_W-bit counter, cleared on every state entry. It never wraps, because every compare is against parameter−1.

Test Plan:
- Bench parameters: LOCK_STABLE=4, SDRAM_WAIT=8, STAGE_GAP=2, SOFT_HOLD=3.
- Clean power-up: `pll_locked` rises before edge k and stays high -> rst_sdram falls at k+6, rst_memory at k+14, rst_cpu and ready at k+16; lock_loss_count = 0.
- Glitch in STABLE: `pll_locked` high 3 cycles, low 1 cycle, then high -> sequence restarts from WAIT_LOCK; rst_sdram never falls early; lock_loss_count stays 0.
- Lock loss in RUN: drop `pll_locked` -> 2 edges later `lk_s` = 0; next edge all resets = 1, ready = 0, lock_loss_count = 1; re-lock reruns the full sequence.
- Soft reset: 1-cycle soft_reset pulse in RUN -> rst_cpu high for 3 cycles; rst_sdram and rst_memory stay 0. A second pulse during the hold extends it to 3 cycles after the second pulse. soft_reset asserted during SDRAM has no effect.
- Simultaneous: soft_reset and lock loss on the same edge in RUN -> WAIT_LOCK wins.
- Saturation: force 260 lock losses after SDRAM release -> lock_loss_count = 255.
- Async reset: assert `reset_n` low mid-SDRAM state and off-edge -> all resets 1 immediately, without waiting for a clock edge; lock_loss_count = 0.
- Invariants asserted throughout all of the above.

Source files
------------

// File: rtl/ulx3s_reset_sequencer_if.sv
// rtl/ulx3s_reset_sequencer_if.sv - lock/soft-reset inputs and staged reset outputs of the reset sequencer
interface ulx3s_reset_sequencer_if;
    logic       pll_locked;
    logic       soft_reset;
    logic       rst_sdram;
    logic       rst_memory;
    logic       rst_cpu;
    logic       ready;
    logic [7:0] lock_loss_count;

    modport master (
        output pll_locked,
        output soft_reset,
        input  rst_sdram,
        input  rst_memory,
        input  rst_cpu,
        input  ready,
        input  lock_loss_count
    );

    modport slave (
        input  pll_locked,
        input  soft_reset,
        output rst_sdram,
        output rst_memory,
        output rst_cpu,
        output ready,
        output lock_loss_count
    );
endinterface

// File: rtl/ulx3s_reset_sequencer.sv
// rtl/ulx3s_reset_sequencer.sv - staged SDRAM/memory/CPU reset release behind PLL lock, with soft CPU reset
module ulx3s_reset_sequencer #(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int SDRAM_WAIT_CYCLES  = 10000,
    parameter int STAGE_GAP_CYCLES   = 16,
    parameter int SOFT_HOLD_CYCLES   = 16,
    parameter int CNT_W              = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    ulx3s_reset_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABLE    = 3'd1,
        SDRAM     = 3'd2,
        MEM       = 3'd3,
        RUN       = 3'd4,
        SOFT      = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SDRAM_LAST = CNT_W'(SDRAM_WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(STAGE_GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] SOFT_LAST  = CNT_W'(SOFT_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state_q, state_d;
    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       loss_q, loss_d;
    logic             rst_sdram_q, rst_sdram_d;
    logic             rst_memory_q, rst_memory_d;
    logic             rst_cpu_q, rst_cpu_d;
    logic             ready_q, ready_d;
    logic             lk_s;

    assign lk_s = sync_q[1];

    always_comb begin
        sync_d       = {sync_q[0], bus.pll_locked};
        state_d      = state_q;
        cnt_d        = cnt_q;
        loss_d       = loss_q;

        // Loss of lock after SDRAM release overrides soft reset and stage completion.
        if ((state_q inside {SDRAM, MEM, RUN, SOFT}) && !lk_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
            if (loss_q != 8'hFF) begin
                loss_d = loss_q + 8'd1;
            end
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    if (lk_s) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                    end
                end
                STABLE: begin
                    if (!lk_s) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == LOCK_LAST) begin
                        state_d = SDRAM;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                SDRAM: begin
                    if (cnt_q == SDRAM_LAST) begin
                        state_d = MEM;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                MEM: begin
                    if (cnt_q == GAP_LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                RUN: begin
                    if (bus.soft_reset) begin
                        state_d = SOFT;
                        cnt_d   = '0;
                    end
                end
                SOFT: begin
                    if (bus.soft_reset) begin
                        cnt_d = '0;
                    end else if (cnt_q == SOFT_LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            endcase
        end

        // Outputs are decoded from the next state so they change on the entering edge.
        rst_sdram_d  = (state_d == WAIT_LOCK) || (state_d == STABLE);
        rst_memory_d = rst_sdram_d || (state_d == SDRAM);
        rst_cpu_d    = (state_d != RUN);
        ready_d      = (state_d == RUN);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= WAIT_LOCK;
            sync_q       <= 2'b00;
            cnt_q        <= '0;
            loss_q       <= 8'd0;
            rst_sdram_q  <= 1'b1;
            rst_memory_q <= 1'b1;
            rst_cpu_q    <= 1'b1;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            cnt_q        <= cnt_d;
            loss_q       <= loss_d;
            rst_sdram_q  <= rst_sdram_d;
            rst_memory_q <= rst_memory_d;
            rst_cpu_q    <= rst_cpu_d;
            ready_q      <= ready_d;
        end
    end

    assign bus.rst_sdram       = rst_sdram_q;
    assign bus.rst_memory      = rst_memory_q;
    assign bus.rst_cpu         = rst_cpu_q;
    assign bus.ready           = ready_q;
    assign bus.lock_loss_count = loss_q;

endmodule

// File: tb/tb_ulx3s_reset_sequencer.sv
// tb/tb_ulx3s_reset_sequencer.sv - directed self-checking bench for ulx3s_reset_sequencer
module tb_ulx3s_reset_sequencer;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    ulx3s_reset_sequencer_if bus_if ();

    ulx3s_reset_sequencer #(
        .LOCK_STABLE_CYCLES (4),
        .SDRAM_WAIT_CYCLES  (8),
        .STAGE_GAP_CYCLES   (2),
        .SOFT_HOLD_CYCLES   (3),
        .CNT_W              (16)
    ) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus_if)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_outs(input string tag, input logic s, input logic m, input logic c,
                              input logic r, input logic [7:0] cnt);
        check({tag, "_outs"}, {28'd0, bus_if.rst_sdram, bus_if.rst_memory, bus_if.rst_cpu, bus_if.ready},
              {28'd0, s, m, c, r});
        check({tag, "_loss"}, {24'd0, bus_if.lock_loss_count}, {24'd0, cnt});
    endtask

    // Full lock-to-RUN sequence, starting in WAIT_LOCK with lk_s low; pulses soft_reset during SDRAM.
    task automatic power_up(input logic [7:0] loss);
        bus_if.pll_locked = 1'b1;
        tick(6);
        check_outs("pu_k5", 1, 1, 1, 0, loss);
        tick(1);
        check_outs("pu_k6", 0, 1, 1, 0, loss);
        bus_if.soft_reset = 1'b1;
        tick(1);
        bus_if.soft_reset = 1'b0;
        check_outs("pu_k7_soft_ignored", 0, 1, 1, 0, loss);
        tick(6);
        check_outs("pu_k13", 0, 1, 1, 0, loss);
        tick(1);
        check_outs("pu_k14", 0, 0, 1, 0, loss);
        tick(1);
        check_outs("pu_k15", 0, 0, 1, 0, loss);
        tick(1);
        check_outs("pu_k16", 0, 0, 0, 1, loss);
    endtask

    always @(negedge clk) begin
        check("inv", {29'd0,
                      (bus_if.rst_sdram <= bus_if.rst_memory),
                      (bus_if.rst_memory <= bus_if.rst_cpu),
                      (bus_if.ready == (~bus_if.rst_cpu & ~bus_if.rst_memory & ~bus_if.rst_sdram))},
              32'd7);
    end

    initial begin
        n_pass            = 0;
        n_total           = 0;
        rst_n             = 1'b0;
        bus_if.pll_locked = 1'b0;
        bus_if.soft_reset = 1'b0;
        tick(3);
        check_outs("reset", 1, 1, 1, 0, 8'd0);
        rst_n = 1'b1;
        tick(3);
        check_outs("wait_lock", 1, 1, 1, 0, 8'd0);

        power_up(8'd0);

        // Single soft-reset pulse in RUN.
        bus_if.soft_reset = 1'b1;
        tick(1);
        bus_if.soft_reset = 1'b0;
        check_outs("soft_e0", 0, 0, 1, 0, 8'd0);
        tick(1);
        check_outs("soft_e1", 0, 0, 1, 0, 8'd0);
        tick(1);
        check_outs("soft_e2", 0, 0, 1, 0, 8'd0);
        tick(1);
        check_outs("soft_e3", 0, 0, 0, 1, 8'd0);

        // Retrigger during the hold.
        bus_if.soft_reset = 1'b1;
        tick(1);
        bus_if.soft_reset = 1'b0;
        tick(1);
        bus_if.soft_reset = 1'b1;
        tick(1);
        bus_if.soft_reset = 1'b0;
        check_outs("retrig_e2", 0, 0, 1, 0, 8'd0);
        tick(2);
        check_outs("retrig_e4", 0, 0, 1, 0, 8'd0);
        tick(1);
        check_outs("retrig_e5", 0, 0, 0, 1, 8'd0);

        // Lock loss in RUN.
        bus_if.pll_locked = 1'b0;
        tick(2);
        check_outs("loss_l1", 0, 0, 0, 1, 8'd0);
        tick(1);
        check_outs("loss_l2", 1, 1, 1, 0, 8'd1);
        tick(2);
        power_up(8'd1);

        // Soft reset and lock loss evaluated on the same edge.
        bus_if.pll_locked = 1'b0;
        tick(2);
        bus_if.soft_reset = 1'b1;
        tick(1);
        bus_if.soft_reset = 1'b0;
        check_outs("simul", 1, 1, 1, 0, 8'd2);
        tick(2);

        // One-cycle glitch on pll_locked while in STABLE.
        bus_if.pll_locked = 1'b1;
        tick(3);
        bus_if.pll_locked = 1'b0;
        tick(1);
        bus_if.pll_locked = 1'b1;
        tick(3);
        check_outs("glitch_k6", 1, 1, 1, 0, 8'd2);
        tick(3);
        check_outs("glitch_k9", 1, 1, 1, 0, 8'd2);
        tick(1);
        check_outs("glitch_k10", 0, 1, 1, 0, 8'd2);
        tick(8);
        check_outs("glitch_k18", 0, 0, 1, 0, 8'd2);
        tick(2);
        check_outs("glitch_k20", 0, 0, 0, 1, 8'd2);

        // 260 lock losses after SDRAM release: first from RUN, then 259 from SDRAM.
        bus_if.pll_locked = 1'b0;
        tick(4);
        check_outs("sat_first", 1, 1, 1, 0, 8'd3);
        bus_if.pll_locked = 1'b1;
        tick(8);
        check_outs("sat_in_sdram", 0, 1, 1, 0, 8'd3);
        bus_if.pll_locked = 1'b0;
        tick(4);
        check_outs("sat_second", 1, 1, 1, 0, 8'd4);
        for (int i = 0; i < 258; i++) begin
            bus_if.pll_locked = 1'b1;
            tick(8);
            bus_if.pll_locked = 1'b0;
            tick(4);
        end
        check_outs("sat_final", 1, 1, 1, 0, 8'd255);

        // Asynchronous reset mid-SDRAM, applied away from any clock edge.
        bus_if.pll_locked = 1'b1;
        tick(8);
        check_outs("pre_async", 0, 1, 1, 0, 8'd255);
        #5;
        rst_n = 1'b0;
        #1;
        check_outs("async", 1, 1, 1, 0, 8'd0);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
